// File: rtl/core_seq.sv
// Instruction sequencer for core: drives the 34-bit inst word through one full
// convolution tile (weight/activation fetch, load, execute, drain, accumulate).
module core_seq #(
  parameter int row      = 8,
  parameter int col      = 8,
  parameter int len_nij  = 36,
  parameter int len_kij  = 9,
  parameter int len_onij = 16,
  parameter int w_base   = 1024,
  parameter int gap      = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        ofifo_valid,
  input  logic [10:0] acc_addr,
  output logic [33:0] inst,
  output logic [7:0]  acc_idx,
  output logic        busy,
  output logic        done,
  output logic        out_valid,
  output logic        sfp_clr
);

  localparam logic [33:0] INST_IDLE = 34'h1_800C_0000;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // One phase counter is shared by every state, so it must cover the longest phase.
  localparam int CNT_MAX = max2(max2(max2(col + 1, len_nij + 1), max2(gap, len_kij + 2)), row);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_W_L0, S_LOAD, S_GAP, S_X_L0, S_EXEC, S_DRAIN, S_ACC, S_FIN
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       kij;
  logic [7:0]       pix;
  logic [10:0]      w_addr;
  logic [10:0]      d_addr;
  logic             w_last;
  logic             x_last;

  assign w_addr = 11'(w_base) + 11'(kij) * 11'(col) + 11'(cnt);
  assign d_addr = 11'(kij) * 11'(len_nij) + 11'(cnt);
  assign w_last = (cnt == CNT_W'(col));
  assign x_last = (cnt == CNT_W'(len_nij));

  function automatic logic [33:0] mk_inst(
    input logic        acc,
    input logic        cen_p,
    input logic        wen_p,
    input logic [10:0] a_p,
    input logic        cen_x,
    input logic        wen_x,
    input logic [10:0] a_x,
    input logic [6:0]  ctl
  );
    return {acc, cen_p, wen_p, a_p, cen_x, wen_x, a_x, ctl};
  endfunction

  // The word issued at each edge is derived from the state held before that edge,
  // so l0_wr naturally trails the xmem read by one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      kij       <= '0;
      pix       <= '0;
      inst      <= INST_IDLE;
      acc_idx   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      out_valid <= 1'b0;
      sfp_clr   <= 1'b0;
    end else begin
      inst      <= INST_IDLE;
      done      <= 1'b0;
      out_valid <= 1'b0;
      sfp_clr   <= 1'b0;
      busy      <= (state != S_IDLE) && (state != S_FIN);
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_W_L0;
            cnt   <= '0;
            kij   <= '0;
          end
        end
        S_W_L0: begin
          inst <= mk_inst(1'b0, 1'b1, 1'b1, 11'd0, w_last, 1'b1, w_last ? 11'd0 : w_addr,
                          {4'b0000, cnt != '0, 2'b00});
          if (w_last) begin
            state <= S_LOAD;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_LOAD: begin
          inst <= mk_inst(1'b0, 1'b1, 1'b1, 11'd0, 1'b1, 1'b1, 11'd0, 7'b0001001);
          if (cnt == CNT_W'(col - 1)) begin
            state <= S_GAP;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_GAP: begin
          if (cnt == CNT_W'(gap - 1)) begin
            state <= S_X_L0;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_X_L0: begin
          inst <= mk_inst(1'b0, 1'b1, 1'b1, 11'd0, x_last, 1'b1, x_last ? 11'd0 : 11'(cnt),
                          {4'b0000, cnt != '0, 2'b00});
          if (x_last) begin
            state <= S_EXEC;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_EXEC: begin
          inst <= mk_inst(1'b0, 1'b1, 1'b1, 11'd0, 1'b1, 1'b1, 11'd0, 7'b0001010);
          if (cnt == CNT_W'(len_nij - 1)) begin
            state <= S_DRAIN;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_DRAIN: begin
          // Skipping a cycle after each read keeps us from over-reading the OFIFO,
          // whose valid flag reacts one cycle after our registered ofifo_rd.
          if (ofifo_valid && !inst[6]) begin
            inst <= mk_inst(1'b0, 1'b0, 1'b0, d_addr, 1'b1, 1'b1, 11'd0, 7'b1000000);
            if (cnt == CNT_W'(len_nij - 1)) begin
              cnt <= '0;
              if (kij == 4'(len_kij - 1)) begin
                state   <= S_ACC;
                kij     <= '0;
                pix     <= '0;
                acc_idx <= '0;
              end else begin
                state <= S_W_L0;
                kij   <= kij + 4'd1;
              end
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        S_ACC: begin
          if (cnt < CNT_W'(len_kij)) begin
            inst    <= mk_inst(cnt != '0, 1'b0, 1'b1, acc_addr, 1'b1, 1'b1, 11'd0, 7'b0000000);
            acc_idx <= acc_idx + 8'd1;
          end else if (cnt == CNT_W'(len_kij)) begin
            inst <= mk_inst(1'b1, 1'b1, 1'b1, 11'd0, 1'b1, 1'b1, 11'd0, 7'b0000000);
          end else begin
            out_valid <= 1'b1;
            sfp_clr   <= 1'b1;
          end
          if (cnt == CNT_W'(len_kij + 1)) begin
            cnt <= '0;
            if (pix == 8'(len_onij - 1)) begin
              state <= S_FIN;
            end else begin
              pix <= pix + 8'd1;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_FIN: begin
          done    <= 1'b1;
          acc_idx <= '0;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_core_seq.sv
// Directed bench for core_seq: logs each tile cycle by cycle and checks the
// fetch, load, execute, drain and accumulate phases against hand-derived values.
module tb_core_seq;

  localparam logic [33:0] INST_IDLE = 34'h1_800C_0000;
  localparam int MAXLOG = 6000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        ofifo_valid = 1'b0;
  logic [10:0] acc_addr;
  logic [33:0] inst;
  logic [7:0]  acc_idx;
  logic        busy, done, out_valid, sfp_clr;

  int checks = 0;
  int failures = 0;
  int run_id = 0;
  int n_log = 0;

  logic [33:0] log_inst [MAXLOG];
  logic [7:0]  log_idx  [MAXLOG];
  logic        log_busy [MAXLOG];
  logic        log_ov   [MAXLOG];
  logic        log_clr  [MAXLOG];
  logic        log_done [MAXLOG];
  logic        log_fv   [MAXLOG];

  always #5 clk = ~clk;

  assign acc_addr = 11'(acc_idx) + 11'd100;

  core_seq dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .ofifo_valid (ofifo_valid),
    .acc_addr    (acc_addr),
    .inst        (inst),
    .acc_idx     (acc_idx),
    .busy        (busy),
    .done        (done),
    .out_valid   (out_valid),
    .sfp_clr     (sfp_clr)
  );

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog simulation did not finish, time=%0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  // Index 0 of the log is the sample just after the edge that accepts start.
  task automatic capture(input bit hold_start, input bit rand_valid);
    bit got_done;
    got_done = 1'b0;
    n_log = 0;
    run_id++;
    ofifo_valid = 1'b1;
    start = 1'b1;
    while (!got_done && n_log < MAXLOG) begin
      @(negedge clk);
      log_inst[n_log] = inst;
      log_idx[n_log]  = acc_idx;
      log_busy[n_log] = busy;
      log_ov[n_log]   = out_valid;
      log_clr[n_log]  = sfp_clr;
      log_done[n_log] = done;
      got_done = done;
      if (!hold_start) start = 1'b0;
      ofifo_valid = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
      log_fv[n_log] = ofifo_valid;
      n_log++;
    end
    checks++;
    if (!got_done) begin
      failures++;
      $display("[TB] FAIL tile_timeout run=%0d done=%0b required=1 within %0d cycles", run_id, got_done, MAXLOG);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (inst !== INST_IDLE) begin
        failures++;
        $display("[TB] FAIL reset_inst cycle=%0d got=%h required=%h", i, inst, INST_IDLE);
      end
      checks++;
      if ({busy, done} !== 2'b00) begin
        failures++;
        $display("[TB] FAIL reset_busy_done cycle=%0d got=%b required=00", i, {busy, done});
      end
    end
  endtask

  task automatic test_weight_fetch;
    logic [33:0] w;
    logic exp_wr;
    checks++;
    if (log_inst[0] !== INST_IDLE) begin
      failures++;
      $display("[TB] FAIL first_word_lag run=%0d got=%h required=%h", run_id, log_inst[0], INST_IDLE);
    end
    checks++;
    if (log_busy[1] !== 1'b1) begin
      failures++;
      $display("[TB] FAIL busy_rise run=%0d got=%b required=1", run_id, log_busy[1]);
    end
    for (int t = 0; t < 8; t++) begin
      w = log_inst[1 + t];
      checks++;
      if ({w[19], w[18], w[17:7]} !== {1'b0, 1'b1, 11'(1024 + t)}) begin
        failures++;
        $display("[TB] FAIL w_l0_addr run=%0d t=%0d got=%b_%b_%0d required=0_1_%0d", run_id, t, w[19], w[18], w[17:7], 1024 + t);
      end
    end
    checks++;
    if (log_inst[9] !== (INST_IDLE | 34'h4)) begin
      failures++;
      $display("[TB] FAIL w_l0_tail run=%0d got=%h required=%h", run_id, log_inst[9], INST_IDLE | 34'h4);
    end
    for (int k = 1; k <= 9; k++) begin
      exp_wr = (k >= 2);
      checks++;
      if (log_inst[k][2] !== exp_wr) begin
        failures++;
        $display("[TB] FAIL w_l0_wr run=%0d idx=%0d got=%b required=%b", run_id, k, log_inst[k][2], exp_wr);
      end
    end
  endtask

  task automatic test_load_gap;
    for (int k = 10; k <= 17; k++) begin
      checks++;
      if (log_inst[k] !== (INST_IDLE | 34'h9)) begin
        failures++;
        $display("[TB] FAIL load_word run=%0d idx=%0d got=%h required=%h", run_id, k, log_inst[k], INST_IDLE | 34'h9);
      end
    end
    for (int k = 18; k <= 27; k++) begin
      checks++;
      if (log_inst[k] !== INST_IDLE) begin
        failures++;
        $display("[TB] FAIL gap_word run=%0d idx=%0d got=%h required=%h", run_id, k, log_inst[k], INST_IDLE);
      end
    end
  endtask

  task automatic test_act_exec;
    logic [33:0] w;
    for (int k = 28; k <= 63; k++) begin
      w = log_inst[k];
      checks++;
      if ({w[19], w[17:7], w[2]} !== {1'b0, 11'(k - 28), (k != 28)}) begin
        failures++;
        $display("[TB] FAIL x_l0_word run=%0d t=%0d got=%b_%0d_%b required=0_%0d_%b", run_id, k - 28, w[19], w[17:7], w[2], k - 28, k != 28);
      end
    end
    checks++;
    if (log_inst[64] !== (INST_IDLE | 34'h4)) begin
      failures++;
      $display("[TB] FAIL x_l0_tail run=%0d got=%h required=%h", run_id, log_inst[64], INST_IDLE | 34'h4);
    end
    for (int k = 65; k <= 100; k++) begin
      checks++;
      if (log_inst[k] !== (INST_IDLE | 34'hA)) begin
        failures++;
        $display("[TB] FAIL exec_word run=%0d idx=%0d got=%h required=%h", run_id, k, log_inst[k], INST_IDLE | 34'hA);
      end
    end
    checks++;
    if (log_inst[101][1] !== 1'b0) begin
      failures++;
      $display("[TB] FAIL exec_length run=%0d got=%b required=0", run_id, log_inst[101][1]);
    end
  endtask

  task automatic test_drain;
    logic [33:0] w;
    logic prev_rd;
    int nd;
    nd = 0;
    prev_rd = 1'b0;
    for (int k = 0; k < n_log; k++) begin
      w = log_inst[k];
      if (w[6]) begin
        checks++;
        if (w[32:20] !== {2'b00, 11'(nd)}) begin
          failures++;
          $display("[TB] FAIL drain_addr run=%0d n=%0d got=%b_%b_%0d required=0_0_%0d", run_id, nd, w[32], w[31], w[30:20], nd);
        end
        checks++;
        if (prev_rd) begin
          failures++;
          $display("[TB] FAIL drain_back_to_back run=%0d idx=%0d got=1 required=0", run_id, k);
        end
        if (k > 0) begin
          checks++;
          if (log_fv[k - 1] !== 1'b1) begin
            failures++;
            $display("[TB] FAIL drain_without_valid run=%0d idx=%0d got=%b required=1", run_id, k, log_fv[k - 1]);
          end
        end
        if ((nd % 36) != 35 && k + 1 < n_log) begin
          checks++;
          if (log_inst[k + 1] !== INST_IDLE) begin
            failures++;
            $display("[TB] FAIL drain_separator run=%0d n=%0d got=%h required=%h", run_id, nd, log_inst[k + 1], INST_IDLE);
          end
        end
        nd++;
      end
      prev_rd = w[6];
    end
    checks++;
    if (nd != 324) begin
      failures++;
      $display("[TB] FAIL drain_total run=%0d got=%0d required=324", run_id, nd);
    end
  endtask

  task automatic test_accumulate;
    logic [33:0] w;
    int rd, nov, last_ov, acc_run, ndone;
    rd = 0; nov = 0; last_ov = -1; acc_run = 0; ndone = 0;
    for (int k = 1; k < n_log; k++) begin
      w = log_inst[k];
      if (w[32] == 1'b0 && w[31] == 1'b1) begin
        checks++;
        if (w[30:20] !== 11'(100 + rd) || log_idx[k - 1] !== 8'(rd)) begin
          failures++;
          $display("[TB] FAIL acc_read run=%0d j=%0d got=addr%0d_idx%0d required=addr%0d_idx%0d", run_id, rd, w[30:20], log_idx[k - 1], 100 + rd, rd);
        end
        rd++;
      end
      if (w[33]) acc_run++;
      if (log_done[k]) ndone++;
      checks++;
      if (log_clr[k] !== log_ov[k]) begin
        failures++;
        $display("[TB] FAIL sfp_clr_align run=%0d idx=%0d got=%b required=%b", run_id, k, log_clr[k], log_ov[k]);
      end
      if (log_ov[k]) begin
        checks++;
        if (w !== INST_IDLE || acc_run != 9) begin
          failures++;
          $display("[TB] FAIL pixel_end run=%0d pixel=%0d got=%h_acc%0d required=%h_acc9", run_id, nov, w, acc_run, INST_IDLE);
        end
        if (last_ov >= 0) begin
          checks++;
          if (k - last_ov != 11) begin
            failures++;
            $display("[TB] FAIL out_valid_spacing run=%0d pixel=%0d got=%0d required=11", run_id, nov, k - last_ov);
          end
        end
        acc_run = 0;
        last_ov = k;
        nov++;
      end
    end
    checks++;
    if (rd != 144) begin
      failures++;
      $display("[TB] FAIL acc_read_total run=%0d got=%0d required=144", run_id, rd);
    end
    checks++;
    if (nov != 16) begin
      failures++;
      $display("[TB] FAIL out_valid_count run=%0d got=%0d required=16", run_id, nov);
    end
    checks++;
    if (ndone != 1 || (n_log - 1) - last_ov != 1) begin
      failures++;
      $display("[TB] FAIL done_timing run=%0d got=count%0d_lag%0d required=count1_lag1", run_id, ndone, (n_log - 1) - last_ov);
    end
    checks++;
    if ({log_busy[n_log - 2], log_busy[n_log - 1]} !== 2'b10) begin
      failures++;
      $display("[TB] FAIL busy_fall run=%0d got=%b required=10", run_id, {log_busy[n_log - 2], log_busy[n_log - 1]});
    end
  endtask

  task automatic test_reset_midrun;
    ofifo_valid = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (85) @(negedge clk);
    checks++;
    if (inst !== (INST_IDLE | 34'hA)) begin
      failures++;
      $display("[TB] FAIL midrun_exec got=%h required=%h", inst, INST_IDLE | 34'hA);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (inst !== INST_IDLE || {busy, done, out_valid, sfp_clr} !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL midrun_reset got=%h_%b required=%h_0000", inst, {busy, done, out_valid, sfp_clr}, INST_IDLE);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_start_held;
    int starts;
    starts = 0;
    for (int k = 0; k < n_log; k++) begin
      if (log_inst[k][19] == 1'b0 && log_inst[k][17:7] == 11'd1024) starts++;
    end
    checks++;
    if (starts != 1) begin
      failures++;
      $display("[TB] FAIL start_held_restart got=%0d required=1", starts);
    end
    @(negedge clk);
    checks++;
    if (inst !== INST_IDLE) begin
      failures++;
      $display("[TB] FAIL restart_idle got=%h required=%h", inst, INST_IDLE);
    end
    @(negedge clk);
    checks++;
    if ({inst[19], inst[17:7], busy} !== {1'b0, 11'd1024, 1'b1}) begin
      failures++;
      $display("[TB] FAIL restart_first_word got=%b_%0d_%b required=0_1024_1", inst[19], inst[17:7], busy);
    end
    start = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset;

    capture(1'b0, 1'b0);
    test_weight_fetch;
    test_load_gap;
    test_act_exec;
    test_drain;
    test_accumulate;

    capture(1'b0, 1'b1);
    test_weight_fetch;
    test_drain;
    test_accumulate;

    test_reset_midrun;

    capture(1'b1, 1'b0);
    test_weight_fetch;
    test_load_gap;
    test_act_exec;
    test_drain;
    test_accumulate;
    test_start_held;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
